// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared types and constants for the 5x5 convolution window path.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int KERNEL_K      = 5;
  localparam int IMG_W_DEFAULT = 28;
  localparam int IMG_H_DEFAULT = 28;

  typedef logic signed [7:0] pixel_t;
  typedef pixel_t [0:KERNEL_K*KERNEL_K-1] window_t;

endpackage : conv_pkg
`default_nettype wire

// File: rtl/line_delay.sv
`default_nettype none
// ============================================================================
// Module   : line_delay
// Brief    : One image line of delay (DEPTH enabled shifts), circular-pointer RAM.
// Revision : 1.0 - initial release
// ============================================================================
module line_delay #(
  parameter int DEPTH  = 28,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_din,
  output logic signed [DATA_W-1:0] o_dout
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [c_PTR_W-1:0]       r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= (r_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  // Storage is never cleared; the slot under the pointer is the oldest entry.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[r_ptr] <= i_din;
    end
  end

  assign o_dout = r_mem[r_ptr];

endmodule : line_delay
`default_nettype wire

// File: rtl/conv_window_buffer5x5.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_buffer5x5
// Brief    : Raster-stream 5x5 window generator; optional CONV_WINDOW_SOF_CHECK_EN
//            adds a sticky frame_err output for sof/counter disagreement.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_buffer5x5
  import conv_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEFAULT,
  parameter int IMG_H  = IMG_H_DEFAULT,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] pixel_in,
  input  logic                     pixel_valid,
  input  logic                     sof,
  output logic signed [DATA_W-1:0] data_out_0,
  output logic signed [DATA_W-1:0] data_out_1,
  output logic signed [DATA_W-1:0] data_out_2,
  output logic signed [DATA_W-1:0] data_out_3,
  output logic signed [DATA_W-1:0] data_out_4,
  output logic signed [DATA_W-1:0] data_out_5,
  output logic signed [DATA_W-1:0] data_out_6,
  output logic signed [DATA_W-1:0] data_out_7,
  output logic signed [DATA_W-1:0] data_out_8,
  output logic signed [DATA_W-1:0] data_out_9,
  output logic signed [DATA_W-1:0] data_out_10,
  output logic signed [DATA_W-1:0] data_out_11,
  output logic signed [DATA_W-1:0] data_out_12,
  output logic signed [DATA_W-1:0] data_out_13,
  output logic signed [DATA_W-1:0] data_out_14,
  output logic signed [DATA_W-1:0] data_out_15,
  output logic signed [DATA_W-1:0] data_out_16,
  output logic signed [DATA_W-1:0] data_out_17,
  output logic signed [DATA_W-1:0] data_out_18,
  output logic signed [DATA_W-1:0] data_out_19,
  output logic signed [DATA_W-1:0] data_out_20,
  output logic signed [DATA_W-1:0] data_out_21,
  output logic signed [DATA_W-1:0] data_out_22,
  output logic signed [DATA_W-1:0] data_out_23,
  output logic signed [DATA_W-1:0] data_out_24,
`ifdef CONV_WINDOW_SOF_CHECK_EN
  output logic                     frame_err,
`endif
  output logic                     valid_out_buf
);

  localparam int c_K     = KERNEL_K;
  localparam int c_LINES = KERNEL_K - 1;
  localparam int c_TAPS  = KERNEL_K * KERNEL_K;
  localparam int c_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic                     w_accept;
  logic [c_COL_W-1:0]       w_eff_col;
  logic [c_ROW_W-1:0]       w_eff_row;
  logic                     w_col_wrap;
  logic                     w_row_wrap;
  logic                     w_win_hit;
  logic signed [DATA_W-1:0] w_line_out [0:c_LINES-1];
  logic signed [DATA_W-1:0] w_col      [0:c_K-1];

  logic [c_COL_W-1:0]       r_col;
  logic [c_ROW_W-1:0]       r_row;
  logic                     r_valid;
  logic signed [DATA_W-1:0] r_hist [0:c_K-1][0:c_K-2];
  logic signed [DATA_W-1:0] r_win  [0:c_TAPS-1];

  assign w_accept = pixel_valid;

  // Incoming column, top (oldest line) to bottom (current pixel).
  always_comb begin
    w_col[c_K-1] = pixel_in;
    for (int k = 0; k < c_LINES; k++) begin
      w_col[c_K-2-k] = w_line_out[k];
    end
  end

  genvar gi;
  for (gi = 0; gi < c_LINES; gi++) begin : g_line
    line_delay #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W)
    ) u_line (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_accept),
      .i_din  (w_col[c_K-1-gi]),
      .o_dout (w_line_out[gi])
    );
  end

  // sof re-labels the current pixel as (0,0) before any decision is made.
  always_comb begin
    w_eff_col  = sof ? '0 : r_col;
    w_eff_row  = sof ? '0 : r_row;
    w_col_wrap = (w_eff_col == c_COL_W'(IMG_W - 1));
    w_row_wrap = (w_eff_row == c_ROW_W'(IMG_H - 1));
    w_win_hit  = (w_eff_row >= c_ROW_W'(c_K - 1)) && (w_eff_col >= c_COL_W'(c_K - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_col   <= w_col_wrap ? '0 : w_eff_col + 1'b1;
      if (w_col_wrap) begin
        r_row <= w_row_wrap ? '0 : w_eff_row + 1'b1;
      end else begin
        r_row <= w_eff_row;
      end
      r_valid <= w_win_hit;
    end else begin
      r_valid <= 1'b0;
    end
  end

  // r_hist keeps the four previous columns; the output taps only load on a
  // valid window so they hold steady between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_K; i++) begin
        for (int j = 0; j < c_K - 1; j++) begin
          r_hist[i][j] <= '0;
        end
      end
      for (int t = 0; t < c_TAPS; t++) begin
        r_win[t] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < c_K; i++) begin
        for (int j = 0; j < c_K - 2; j++) begin
          r_hist[i][j] <= r_hist[i][j+1];
        end
        r_hist[i][c_K-2] <= w_col[i];
        if (w_win_hit) begin
          for (int j = 0; j < c_K - 1; j++) begin
            r_win[i*c_K+j] <= r_hist[i][j];
          end
          r_win[i*c_K+c_K-1] <= w_col[i];
        end
      end
    end
  end

`ifdef CONV_WINDOW_SOF_CHECK_EN
  logic r_frame_err;
  logic r_sof_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_sof_seen  <= 1'b0;
    end else if (w_accept) begin
      if (sof) begin
        r_sof_seen <= 1'b1;
        if ((r_col != '0) || (r_row != '0)) begin
          r_frame_err <= 1'b1;
        end
      end else if (r_sof_seen && (r_col == '0) && (r_row == '0)) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign frame_err = r_frame_err;
`endif

  assign valid_out_buf = r_valid;

  assign data_out_0  = r_win[0];
  assign data_out_1  = r_win[1];
  assign data_out_2  = r_win[2];
  assign data_out_3  = r_win[3];
  assign data_out_4  = r_win[4];
  assign data_out_5  = r_win[5];
  assign data_out_6  = r_win[6];
  assign data_out_7  = r_win[7];
  assign data_out_8  = r_win[8];
  assign data_out_9  = r_win[9];
  assign data_out_10 = r_win[10];
  assign data_out_11 = r_win[11];
  assign data_out_12 = r_win[12];
  assign data_out_13 = r_win[13];
  assign data_out_14 = r_win[14];
  assign data_out_15 = r_win[15];
  assign data_out_16 = r_win[16];
  assign data_out_17 = r_win[17];
  assign data_out_18 = r_win[18];
  assign data_out_19 = r_win[19];
  assign data_out_20 = r_win[20];
  assign data_out_21 = r_win[21];
  assign data_out_22 = r_win[22];
  assign data_out_23 = r_win[23];
  assign data_out_24 = r_win[24];

endmodule : conv_window_buffer5x5
`default_nettype wire

// File: tb/tb_conv_window_buffer5x5.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_buffer5x5
// Brief    : Self-checking bench for conv_window_buffer5x5 (stream model + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_buffer5x5;

  localparam int W = 28;
  localparam int H = 28;
  localparam int FRAME = W * H;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pixel_valid = 1'b0;
  logic              sof = 1'b0;
  logic signed [7:0] pixel_in = '0;
  logic signed [7:0] d [25];
  logic              valid_out_buf;
`ifdef CONV_WINDOW_SOF_CHECK_EN
  logic              frame_err;
`endif

  always #5 clk = ~clk;

  conv_window_buffer5x5 #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .sof(sof),
    .data_out_0(d[0]),   .data_out_1(d[1]),   .data_out_2(d[2]),   .data_out_3(d[3]),
    .data_out_4(d[4]),   .data_out_5(d[5]),   .data_out_6(d[6]),   .data_out_7(d[7]),
    .data_out_8(d[8]),   .data_out_9(d[9]),   .data_out_10(d[10]), .data_out_11(d[11]),
    .data_out_12(d[12]), .data_out_13(d[13]), .data_out_14(d[14]), .data_out_15(d[15]),
    .data_out_16(d[16]), .data_out_17(d[17]), .data_out_18(d[18]), .data_out_19(d[19]),
    .data_out_20(d[20]), .data_out_21(d[21]), .data_out_22(d[22]), .data_out_23(d[23]),
    .data_out_24(d[24]),
`ifdef CONV_WINDOW_SOF_CHECK_EN
    .frame_err(frame_err),
`endif
    .valid_out_buf(valid_out_buf)
  );

  typedef struct { int t[25]; } win_s;
  typedef struct { string name; int tap; int exp; } tapvec_s;

  int   errors = 0;
  int   checks = 0;
  int   hist[$];
  win_s sb[$];
  win_s last;
  int   mr, mc, nwin, nacc, first_acc;
  bit   got_first;
  int   firstwin[25];

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic cmp_taps(string name, win_s w);
    int bad;
    bad = -1;
    for (int t = 0; t < 25; t++) if (bad < 0 && int'(d[t]) != w.t[t]) bad = t;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: tap %0d got %0d expected %0d", name, bad, int'(d[bad]), w.t[bad]);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    sb.delete();
    mr = 0;
    mc = 0;
    for (int t = 0; t < 25; t++) last.t[t] = 0;
  endtask

  task automatic step(bit pv, bit s, int pix);
    logic signed [7:0] p8;
    win_s w;
    int   n;
    bit   exp_v;
    p8          = pix[7:0];
    pixel_valid = pv;
    sof         = s;
    pixel_in    = p8;
    exp_v       = 1'b0;
    if (pv) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      hist.push_back(int'(p8));
      nacc++;
      if (mr >= 4 && mc >= 4) begin
        n = hist.size() - 1;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            w.t[i*5+j] = hist[n - (4-i)*W - (4-j)];
        sb.push_back(w);
        exp_v = 1'b1;
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
    @(posedge clk);
    #1;
    check("valid_out_buf", int'(valid_out_buf), int'(exp_v));
    if (valid_out_buf) begin
      nwin++;
      if (!got_first) begin
        got_first = 1'b1;
        first_acc = nacc;
        for (int t = 0; t < 25; t++) firstwin[t] = int'(d[t]);
      end
      if (sb.size() == 0) begin
        check("spurious_window", 1, 0);
      end else begin
        w = sb.pop_front();
        cmp_taps("window_taps", w);
        last = w;
      end
    end else begin
      cmp_taps("taps_hold", last);
    end
  endtask

  task automatic do_reset();
    win_s z;
    for (int t = 0; t < 25; t++) z.t[t] = 0;
    rst         = 1'b1;
    pixel_valid = 1'b0;
    sof         = 1'b0;
    #1;
    check("rst_async_valid", int'(valid_out_buf), 0);
    cmp_taps("rst_async_taps", z);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  tapvec_s vecs[5];

  initial begin
    vecs[0] = '{"first_tap0",  0,  0};
    vecs[1] = '{"first_tap4",  4,  4};
    vecs[2] = '{"first_tap12", 12, 58};
    vecs[3] = '{"first_tap20", 20, 112};
    vecs[4] = '{"first_tap24", 24, 116};

    // Reset state before any clock
    model_reset();
    #2;
    check("reset_valid", int'(valid_out_buf), 0);
    cmp_taps("reset_taps", last);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Continuous ramp frame
    nwin = 0; nacc = 0; got_first = 1'b0;
    for (int k = 0; k < FRAME; k++) step(1'b1, k == 0, k % 128);
    check("ramp_windows", nwin, 576);
    check("ramp_first_latency", first_acc, 117);
    for (int v = 0; v < 5; v++) check(vecs[v].name, firstwin[vecs[v].tap], vecs[v].exp);

    // Same ramp with pixel_valid pattern 1,0,0
    nwin = 0; nacc = 0; got_first = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      step(1'b1, k == 0, k % 128);
      step(1'b0, 1'b0, int'($urandom_range(0, 255)));
      step(1'b0, 1'b0, int'($urandom_range(0, 255)));
    end
    check("gap_windows", nwin, 576);
    check("gap_first_latency", first_acc, 117);
    check("gap_first_tap12", firstwin[12], 58);

    // Back-to-back frames, sof only on the first
    nwin = 0;
    for (int k = 0; k < FRAME; k++) step(1'b1, k == 0, k % 128);
    check("b2b_frame1_windows", nwin, 576);
    nwin = 0; nacc = 0; got_first = 1'b0;
    for (int k = 0; k < FRAME; k++) step(1'b1, 1'b0, k % 128);
    check("b2b_frame2_windows", nwin, 576);
    check("b2b_frame2_first_tap24", firstwin[24], 116);

    // Reset at pixel #300 (a window pixel), then a fresh ramp with no sof
    for (int k = 0; k <= 300; k++) step(1'b1, k == 0, k % 128);
    check("pre_rst_valid", int'(valid_out_buf), 1);
    do_reset();
    nwin = 0; nacc = 0; got_first = 1'b0;
    for (int k = 0; k < FRAME; k++) step(1'b1, 1'b0, k % 128);
    check("post_rst_windows", nwin, 576);
    check("post_rst_first_latency", first_acc, 117);

    // sof mid-frame at (10,7)
    do_reset();
`ifdef CONV_WINDOW_SOF_CHECK_EN
    check("frame_err_after_rst", int'(frame_err), 0);
`endif
    for (int k = 0; k < 10*W + 7; k++) step(1'b1, k == 0, k % 128);
`ifdef CONV_WINDOW_SOF_CHECK_EN
    check("frame_err_before_sof", int'(frame_err), 0);
`endif
    nwin = 0; nacc = 0; got_first = 1'b0;
    for (int k = 0; k < FRAME; k++) step(1'b1, k == 0, (k * 3) % 128);
    check("sof_mid_first_latency", first_acc, 117);
    check("sof_mid_windows", nwin, 576);
`ifdef CONV_WINDOW_SOF_CHECK_EN
    check("frame_err_sticky", int'(frame_err), 1);
    do_reset();
    check("frame_err_cleared", int'(frame_err), 0);
`else
    do_reset();
`endif

    // Signed extreme: every pixel -128
    nwin = 0;
    for (int k = 0; k < FRAME; k++) step(1'b1, k == 0, -128);
    check("neg_windows", nwin, 576);
    check("neg_tap0", int'(d[0]), -128);
    check("neg_tap12", int'(d[12]), -128);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_conv_window_buffer5x5
`default_nettype wire

// File: doc/conv_window_buffer5x5.md
Name: conv_window_buffer5x5

Overview:
Streaming 5x5 window generator that feeds depthwise_separable_conv1. It accepts one signed 8-bit pixel per cycle in raster order and keeps four line buffers. It drives the 25 window taps data_out_0..data_out_24 plus valid_out_buf. It sits between the input pixel source and the conv stage, which is purely combinational and has no backpressure.

Parameters:
- IMG_W, 28, pixels per image row.
- IMG_H, 28, rows per frame.
- DATA_W, 8, pixel width (signed).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- pixel_in  input  DATA_W  signed pixel, raster order.
- pixel_valid  input  1  pixel_in accepted on this edge when high; gaps allowed.
- sof  input  1  start-of-frame; qualified by pixel_valid; marks pixel_in as (row 0, col 0).
- data_out_0 .. data_out_24  output  DATA_W each  signed window taps, row-major; data_out_0 = top-left (oldest row, oldest col), data_out_24 = bottom-right (newest pixel).
- valid_out_buf  output  1  window taps valid this cycle (one-cycle pulse per window).

Behaviour:
- Reset (async, rst=1): col=0, row=0, valid_out_buf=0, all 25 window registers=0. Line-buffer RAM contents are not cleared; they are don't-care until refilled.
- Accept: the edge with pixel_valid=1. Cycles without pixel_valid freeze all state. valid_out_buf drops to 0 on the next edge.
- On accept:
  - Each line buffer shifts one entry; line k output feeds line k+1.
  - The window shifts left one column.
  - The new right column is {line3_out, line2_out, line1_out, line0_out, pixel_in}, top to bottom.
- Counters:
  - col increments and wraps IMG_W-1 -> 0.
  - On a col wrap, row increments; row wraps IMG_H-1 -> 0, so back-to-back frames need no sof.
- sof with pixel_valid forces that pixel to col=0, row=0 (counters then advance from there). sof without pixel_valid is ignored.
- Output rule: valid_out_buf=1 on the edge after accepting pixel (r,c) with r>=4 and c>=4. Window taps are registered on that same edge. Latency is 1 cycle from the bottom-right pixel.
- No padding: exactly (IMG_H-4)*(IMG_W-4) windows per frame (576 at defaults).
- Taps hold their last value while valid_out_buf=0.
- Columns c<4 after a row wrap contain previous-row data; they are never flagged valid.
- Widths: pure data movement, no arithmetic on pixels. col is $clog2(IMG_W) bits; row is $clog2(IMG_H) bits.
- Reset mid-frame: valid_out_buf drops asynchronously. The next accepted pixel is (0,0); no windows are issued until row 4, col 4 of the new frame.

Optional Feature:
- Macro: CONV_WINDOW_SOF_CHECK_EN.
- With the macro defined, the block adds output frame_err (1 bit, reset 0).
  - frame_err is set sticky when sof is accepted while the counters are not at (0,0).
  - It is also set when an accepted pixel wraps to (0,0) without sof, after the first sof has been seen.
  - It clears only on rst.
- Without the macro, the port and its logic are absent and sof behaves as described above.

Decomposition:
- Shared package conv_pkg holds:
  - typedef pixel_t (logic signed [7:0]).
  - localparam KERNEL_K=5.
  - Default IMG_W / IMG_H = 28.
  - typedef window_t (pixel_t [0:24]) for internal use.
- One sub-module, line_delay: single-line delay of depth IMG_W with shift enable.
  - Implemented as a RAM with circular pointer, or as a shift register.
  - Instantiated 4 times.
- The window array and counters stay in the top module.

Test Plan:
- Ramp frame: pixel_in=(r*28+c) mod 128, pixel_valid=1 continuously.
  - First valid_out_buf is 1 cycle after pixel #116 (r4,c4).
  - That window has data_out_0=0, data_out_4=4, data_out_12=58, data_out_20=112, data_out_24=116.
  - Total valid pulses = 576.
- Same ramp with pixel_valid toggling 1,0,0 repeatedly: identical window sequence to the ramp frame, valid pulses only after accepts, taps held during gaps.
- Back-to-back frames, sof only on the first frame: the second frame also yields exactly 576 windows. Its first window's data_out_24 = 116.
- rst asserted at pixel #300 for 2 cycles, then a fresh ramp from 0:
  - valid_out_buf low immediately.
  - First valid 1 cycle after the new pixel #116.
  - No spurious window before it.
- sof at pixel (10,7) mid-frame: counters restart; the next valid occurs 1 cycle after the 117th pixel from sof. With CONV_WINDOW_SOF_CHECK_EN, frame_err=1 and it stays 1 until rst.
- Signed data: all pixels = -128 (0x80). Every valid window has all 25 taps = -128, with no sign corruption through the line buffers.
